// File: rtl/svm_ctrl_pkg.sv
// Shared types and default widths for the SVM control/status bank.
package svm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } chan_state_t;

    localparam int CL_W_DEF    = 4;
    localparam int STATE_W_DEF = 4;

endpackage

// File: rtl/svm_ctrl_regbank_if.sv
// Register-file side and core side signals of the SVM control/status bank.
interface svm_ctrl_regbank_if
    import svm_ctrl_pkg::*;
#(
    parameter int NUM_CORES = 1,
    parameter int CL_W      = CL_W_DEF,
    parameter int STATE_W   = STATE_W_DEF,
    parameter int CNT_W     = 16
);
    logic [NUM_CORES-1:0]         start_axi_i;
    logic [NUM_CORES-1:0]         done_ack_i;
    logic                         irq_en_i;
    logic [NUM_CORES-1:0]         start_svm_o;
    logic [NUM_CORES-1:0]         ready_svm_i;
    logic [NUM_CORES*CL_W-1:0]    cl_num_svm_i;
    logic [NUM_CORES*STATE_W-1:0] state_svm_i;
    logic [NUM_CORES-1:0]         ready_axi_o;
    logic [NUM_CORES-1:0]         busy_o;
    logic [NUM_CORES-1:0]         err_o;
    logic [NUM_CORES*CL_W-1:0]    cl_num_axi_o;
    logic [NUM_CORES*STATE_W-1:0] state_axi_o;
    logic [CNT_W-1:0]             done_cnt_o;
    logic                         irq_o;

    modport slave (
        input  start_axi_i, done_ack_i, irq_en_i, ready_svm_i, cl_num_svm_i, state_svm_i,
        output start_svm_o, ready_axi_o, busy_o, err_o, cl_num_axi_o, state_axi_o,
               done_cnt_o, irq_o
    );

    modport master (
        output start_axi_i, done_ack_i, irq_en_i, ready_svm_i, cl_num_svm_i, state_svm_i,
        input  start_svm_o, ready_axi_o, busy_o, err_o, cl_num_axi_o, state_axi_o,
               done_cnt_o, irq_o
    );
endinterface

// File: rtl/svm_ctrl_chan.sv
// One core channel: start edge detect, start/ready handshake, result capture, flags.
//
// state | meaning
// IDLE  | waiting for a start request
// START | start held to the core until it drops ready, or timeout
// BUSY  | core classifying, waiting for ready to return
// DONE  | result captured, sticky done flag set until ack or new request
module svm_ctrl_chan
    import svm_ctrl_pkg::*;
#(
    parameter int CL_W    = CL_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_axi,
    input  logic            done_ack,
    input  logic            ready_svm,
    input  logic [CL_W-1:0] cl_num_svm,
    output logic            start_svm,
    output logic            busy,
    output logic            ready_axi,
    output logic            err,
    output logic [CL_W-1:0] cl_num_axi,
    output logic            done_pulse
);
    // Timer counts down the remaining START cycles; zero is the last allowed one.
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    chan_state_t     state_q, state_d;
    logic            start_q;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [CL_W-1:0] cl_q, cl_d;
    logic            req;

    assign req = start_axi & ~start_q;

    // State, timer, flags and captured result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            tmr_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cl_q    <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_axi;
            tmr_q   <= tmr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cl_q    <= cl_d;
        end
    end

    // Next state, timer and flag updates; a request while running only flags an error.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        ready_d    = ready_q;
        err_d      = err_q;
        cl_d       = cl_q;
        done_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = START;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    tmr_d   = TMR_LOAD;
                end else if (done_ack) begin
                    err_d = 1'b0;
                end
            end
            START: begin
                if (done_ack) err_d = 1'b0;
                if (req)      err_d = 1'b1;
                if (!ready_svm) begin
                    state_d = BUSY;
                end else if (tmr_q == '0) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            BUSY: begin
                if (done_ack) err_d = 1'b0;
                if (req)      err_d = 1'b1;
                if (ready_svm) begin
                    state_d    = DONE;
                    cl_d       = cl_num_svm;
                    ready_d    = 1'b1;
                    done_pulse = 1'b1;
                end
            end
            DONE: begin
                if (req) begin
                    state_d = START;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    tmr_d   = TMR_LOAD;
                end else if (done_ack) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_svm  = (state_q == START);
    assign busy       = (state_q == START) || (state_q == BUSY);
    assign ready_axi  = ready_q;
    assign err        = err_q;
    assign cl_num_axi = cl_q;
endmodule

// File: rtl/svm_ctrl_regbank.sv
// Control/status bank between the register file and NUM_CORES SVM cores.
module svm_ctrl_regbank
    import svm_ctrl_pkg::*;
#(
    parameter int NUM_CORES = 1,
    parameter int CL_W      = CL_W_DEF,
    parameter int STATE_W   = STATE_W_DEF,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input logic               clk,
    input logic               reset,
    svm_ctrl_regbank_if.slave bus
);
    localparam int SUM_W = CNT_W + 3;
    localparam logic [SUM_W-1:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

    logic [NUM_CORES-1:0]         start_svm, busy, ready_axi, err, done_pulse;
    logic [NUM_CORES*CL_W-1:0]    cl_num;
    logic [NUM_CORES*STATE_W-1:0] state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         irq_q;
    logic [3:0]                   n_done;
    logic [SUM_W-1:0]             cnt_sum;

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_chan
        svm_ctrl_chan #(
            .CL_W    (CL_W),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .start_axi  (bus.start_axi_i[c]),
            .done_ack   (bus.done_ack_i[c]),
            .ready_svm  (bus.ready_svm_i[c]),
            .cl_num_svm (bus.cl_num_svm_i[c*CL_W +: CL_W]),
            .start_svm  (start_svm[c]),
            .busy       (busy[c]),
            .ready_axi  (ready_axi[c]),
            .err        (err[c]),
            .cl_num_axi (cl_num[c*CL_W +: CL_W]),
            .done_pulse (done_pulse[c])
        );
    end

    // Number of cores completing this cycle, widened sum ahead of the clamp.
    always_comb begin
        n_done = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            n_done = n_done + {3'b000, done_pulse[c]};
        end
        cnt_sum = {3'b000, cnt_q} + SUM_W'(n_done);
    end

    // State pass-through, saturating completion counter and registered interrupt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= bus.state_svm_i;
            cnt_q   <= (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
            irq_q   <= bus.irq_en_i & (|(ready_axi | err));
        end
    end

    assign bus.start_svm_o  = start_svm;
    assign bus.busy_o       = busy;
    assign bus.ready_axi_o  = ready_axi;
    assign bus.err_o        = err;
    assign bus.cl_num_axi_o = cl_num;
    assign bus.state_axi_o  = state_q;
    assign bus.done_cnt_o   = cnt_q;
    assign bus.irq_o        = irq_q;
endmodule

// File: tb/tb_svm_ctrl_regbank.sv
// Randomized scoreboard bench: two 4-core instances share stimulus, one with a
// 2-bit counter so that saturation is exercised alongside normal counting.
module tb_svm_ctrl_regbank;
    localparam int NC  = 4;
    localparam int CLW = 4;
    localparam int STW = 4;
    localparam int TO  = 5;
    localparam int CW  = 16;
    localparam int CWS = 2;
    localparam int NCYC = 4000;

    localparam int P_IDLE = 0, P_START = 1, P_BUSY = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    svm_ctrl_regbank_if #(.NUM_CORES(NC), .CL_W(CLW), .STATE_W(STW), .CNT_W(CW))  bus_a ();
    svm_ctrl_regbank_if #(.NUM_CORES(NC), .CL_W(CLW), .STATE_W(STW), .CNT_W(CWS)) bus_s ();

    svm_ctrl_regbank #(.NUM_CORES(NC), .CL_W(CLW), .STATE_W(STW), .TIMEOUT(TO), .CNT_W(CW))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    svm_ctrl_regbank #(.NUM_CORES(NC), .CL_W(CLW), .STATE_W(STW), .TIMEOUT(TO), .CNT_W(CWS))
        dut_s (.clk(clk), .reset(reset), .bus(bus_s));

    assign bus_s.start_axi_i  = bus_a.start_axi_i;
    assign bus_s.done_ack_i   = bus_a.done_ack_i;
    assign bus_s.irq_en_i     = bus_a.irq_en_i;
    assign bus_s.ready_svm_i  = bus_a.ready_svm_i;
    assign bus_s.cl_num_svm_i = bus_a.cl_num_svm_i;
    assign bus_s.state_svm_i  = bus_a.state_svm_i;

    typedef struct {
        logic [NC-1:0]     start_svm;
        logic [NC-1:0]     ready_axi;
        logic [NC-1:0]     busy;
        logic [NC-1:0]     err;
        logic [NC*CLW-1:0] cl;
        logic [NC*STW-1:0] st;
        logic [CW-1:0]     cnt;
        logic [CWS-1:0]    cnt_s;
        logic              irq;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: per-core phase, cycles spent in START, flags, captured result.
    int            m_ph [NC];
    int            m_t  [NC];
    logic          m_sq [NC];
    logic          m_rdy[NC];
    logic          m_err[NC];
    logic [CLW-1:0] m_cl[NC];
    logic [NC*STW-1:0] m_st;
    longint        m_cnt, m_cnt_s;
    logic          m_irq;

    // Stimulus state
    logic [NC-1:0]     start_v, ack_v, ack_prev, rdy_v;
    logic [NC*CLW-1:0] cl_in;
    logic [NC*STW-1:0] st_in;
    logic              irq_en_v;
    int emu_busy[NC], emu_wait[NC], emu_cnt[NC];
    int rst_hold;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_ph[c] = P_IDLE; m_t[c] = 0; m_sq[c] = 1'b0;
            m_rdy[c] = 1'b0; m_err[c] = 1'b0; m_cl[c] = '0;
        end
        m_st = '0; m_cnt = 0; m_cnt_s = 0; m_irq = 1'b0;
    endtask

    task automatic model_step();
        exp_t e;
        int   ncomp;
        logic any_flag;
        logic req;
        if (!reset) begin
            model_reset();
        end else begin
            any_flag = 1'b0;
            for (int c = 0; c < NC; c++) any_flag = any_flag | m_rdy[c] | m_err[c];
            ncomp = 0;
            for (int c = 0; c < NC; c++) begin
                req = start_v[c] && !m_sq[c];
                m_sq[c] = start_v[c];
                case (m_ph[c])
                    P_IDLE: begin
                        if (req) begin
                            m_ph[c] = P_START; m_rdy[c] = 1'b0; m_err[c] = 1'b0; m_t[c] = 0;
                        end else if (ack_v[c]) m_err[c] = 1'b0;
                    end
                    P_START: begin
                        if (ack_v[c]) m_err[c] = 1'b0;
                        if (req)      m_err[c] = 1'b1;
                        if (!rdy_v[c]) m_ph[c] = P_BUSY;
                        else begin
                            m_t[c]++;
                            if (m_t[c] == TO) begin
                                m_ph[c] = P_IDLE; m_err[c] = 1'b1;
                            end
                        end
                    end
                    P_BUSY: begin
                        if (ack_v[c]) m_err[c] = 1'b0;
                        if (req)      m_err[c] = 1'b1;
                        if (rdy_v[c]) begin
                            m_ph[c] = P_DONE; m_cl[c] = cl_in[c*CLW +: CLW];
                            m_rdy[c] = 1'b1; ncomp++;
                        end
                    end
                    default: begin
                        if (req) begin
                            m_ph[c] = P_START; m_rdy[c] = 1'b0; m_err[c] = 1'b0; m_t[c] = 0;
                        end else if (ack_v[c]) begin
                            m_ph[c] = P_IDLE; m_rdy[c] = 1'b0; m_err[c] = 1'b0;
                        end
                    end
                endcase
            end
            m_cnt   = m_cnt + ncomp;
            if (m_cnt > (64'd1 << CW) - 1) m_cnt = (64'd1 << CW) - 1;
            m_cnt_s = m_cnt_s + ncomp;
            if (m_cnt_s > (64'd1 << CWS) - 1) m_cnt_s = (64'd1 << CWS) - 1;
            m_st  = st_in;
            m_irq = irq_en_v & any_flag;
        end
        for (int c = 0; c < NC; c++) begin
            e.start_svm[c] = (m_ph[c] == P_START);
            e.busy[c]      = (m_ph[c] == P_START) || (m_ph[c] == P_BUSY);
            e.ready_axi[c] = m_rdy[c];
            e.err[c]       = m_err[c];
            e.cl[c*CLW +: CLW] = m_cl[c];
        end
        e.st    = m_st;
        e.cnt   = CW'(m_cnt);
        e.cnt_s = CWS'(m_cnt_s);
        e.irq   = m_irq;
        exp_q.push_back(e);
    endtask

    // Monitor: compares both instances against the oldest expectation after each edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("start_svm", 64'(bus_a.start_svm_o),  64'(e.start_svm));
            check("busy",      64'(bus_a.busy_o),       64'(e.busy));
            check("ready_axi", 64'(bus_a.ready_axi_o),  64'(e.ready_axi));
            check("err",       64'(bus_a.err_o),        64'(e.err));
            check("cl_num",    64'(bus_a.cl_num_axi_o), 64'(e.cl));
            check("state_axi", 64'(bus_a.state_axi_o),  64'(e.st));
            check("done_cnt",  64'(bus_a.done_cnt_o),   64'(e.cnt));
            check("irq",       64'(bus_a.irq_o),        64'(e.irq));
            check("sat_cnt",   64'(bus_s.done_cnt_o),   64'(e.cnt_s));
            check("sat_flags", 64'({bus_s.start_svm_o, bus_s.busy_o, bus_s.ready_axi_o, bus_s.err_o}),
                               64'({e.start_svm, e.busy, e.ready_axi, e.err}));
        end
    end

    initial begin
        model_reset();
        start_v = '0; ack_v = '0; ack_prev = '0; rdy_v = '1;
        cl_in = '0; st_in = '0; irq_en_v = 1'b1; rst_hold = 0;
        for (int c = 0; c < NC; c++) begin
            emu_busy[c] = 0; emu_wait[c] = 0; emu_cnt[c] = 0;
        end
        bus_a.start_axi_i = '0; bus_a.done_ack_i = '0; bus_a.irq_en_i = 1'b1;
        bus_a.ready_svm_i = '1; bus_a.cl_num_svm_i = '0; bus_a.state_svm_i = '0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc < 3) reset = 1'b0;
            else if (rst_hold > 0) begin
                reset = 1'b0; rst_hold--;
            end else begin
                reset = 1'b1;
                if ($urandom_range(0, 399) == 0) rst_hold = $urandom_range(1, 2);
            end

            // Core emulation reacts to the model's view of which channels are starting.
            for (int c = 0; c < NC; c++) begin
                if (emu_busy[c] != 0) begin
                    emu_cnt[c]--;
                    if (emu_cnt[c] == 0) begin
                        rdy_v[c] = 1'b1; emu_busy[c] = 0;
                    end
                end else if (m_ph[c] == P_START) begin
                    if (emu_wait[c] == 0) emu_wait[c] = $urandom_range(1, 7);
                    emu_wait[c]--;
                    if (emu_wait[c] == 0) begin
                        rdy_v[c] = 1'b0; emu_busy[c] = 1;
                        emu_cnt[c] = $urandom_range(1, 12);
                    end
                end else begin
                    emu_wait[c] = 0;
                end
                if ($urandom_range(0, 9) == 0) start_v[c] = ~start_v[c];
                ack_v[c] = !ack_prev[c] && ($urandom_range(0, 4) == 0);
            end
            ack_prev = ack_v;
            if ($urandom_range(0, 49) == 0) irq_en_v = ~irq_en_v;
            cl_in = NC*CLW'($urandom);
            st_in = NC*STW'($urandom);

            bus_a.start_axi_i  = start_v;
            bus_a.done_ack_i   = ack_v;
            bus_a.irq_en_i     = irq_en_v;
            bus_a.ready_svm_i  = rdy_v;
            bus_a.cl_num_svm_i = cl_in;
            bus_a.state_svm_i  = st_in;
            model_step();
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/svm_ctrl_regbank.md
Name: svm_ctrl_regbank

Overview:
- Parametrised AXI-side control/status bank between the AXI-Lite register file and NUM_CORES SVM classification cores.
- Adds the following per core:
  - registered pass-through of core state;
  - start edge detection and a start/ready handshake FSM;
  - result capture;
  - a sticky done flag with acknowledge;
  - start timeout and error flags.
- Also provides a global saturating completion counter and a maskable interrupt.

Parameters:
- NUM_CORES, 1, number of SVM core channels (1..8).
- CL_W, 4, classified-number width per core.
- STATE_W, 4, core state width per core.
- TIMEOUT, 255, cycles allowed in START for the core to drop ready before error (>=1).
- CNT_W, 16, completion counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start_axi_i  in  NUM_CORES  AXI start bit per core; a rising edge requests a run.
- done_ack_i  in  NUM_CORES  one-cycle pulse; clears done/err for that core.
- irq_en_i  in  1  interrupt enable.
- start_svm_o  out  NUM_CORES  start to core, held during START.
- ready_svm_i  in  NUM_CORES  core ready: high when idle, low while classifying.
- cl_num_svm_i  in  NUM_CORES*CL_W  core result; core c occupies bits [c*CL_W +: CL_W].
- state_svm_i  in  NUM_CORES*STATE_W  core state, same packing.
- ready_axi_o  out  NUM_CORES  sticky done flag.
- busy_o  out  NUM_CORES  high in START or BUSY.
- err_o  out  NUM_CORES  sticky error (timeout, or start while busy).
- cl_num_axi_o  out  NUM_CORES*CL_W  captured result.
- state_axi_o  out  NUM_CORES*STATE_W  state_svm_i delayed one clock.
- done_cnt_o  out  CNT_W  saturating count of completions, all cores.
- irq_o  out  1  registered: irq_en_i & OR(ready_axi_o | err_o).

Behaviour:
- Reset: all outputs and internal registers are 0; every FSM goes to IDLE.
  - Reset applies mid-operation as well; captured results are lost.
- state_axi_o: plain register, 1-cycle latency, no gating.
- Edge detect: start_axi_i is registered per core; req = start_axi_i & ~start_q.
  - A held-high level produces exactly one request.
- Per-core FSM, states IDLE, START, BUSY, DONE:
  - IDLE: on req -> START; clear ready_axi_o and err_o; clear timer.
  - START: start_svm_o=1 and the timer increments.
    - ready_svm_i==0 -> BUSY, start_svm_o drops the next cycle.
    - Otherwise, when timer reaches TIMEOUT -> IDLE with err_o=1.
    - Hence start_svm_o is high for at most TIMEOUT cycles.
  - BUSY: on ready_svm_i==1 -> DONE.
    - In the same edge, capture cl_num_svm_i slice into cl_num_axi_o, set ready_axi_o=1, and increment done_cnt.
  - DONE: on req -> START, which clears ready_axi_o; cl_num_axi_o holds until the next capture. On done_ack_i -> IDLE, which clears ready_axi_o and err_o.
- Sticky ready: ready_axi_o stays 1 until done_ack_i or a new req.
- Busy request: req in START or BUSY is ignored and sets err_o=1; the FSM is unaffected.
- Simultaneous events:
  - req and done_ack_i together in DONE: req wins.
  - done_ack_i in START or BUSY: clears err_o only.
  - ready rising in BUSY together with req: completion is taken, req is flagged as a busy error.
- done_cnt_o:
  - Increments by the number of cores completing that cycle (0..NUM_CORES).
  - Saturates at 2^CNT_W-1 and never wraps.
  - Popcount sum is computed at CNT_W+3 bits, then clamped.
- irq_o: one register stage after the flags.

Decomposition:
- Shared package svm_ctrl_pkg:
  - chan_state_t enum (IDLE, START, BUSY, DONE);
  - default width constants CL_W_DEF=4 and STATE_W_DEF=4.
- Sub-module svm_ctrl_chan holds one channel's edge detect, FSM, timer, capture register and flags.
  - It is instantiated NUM_CORES times via generate.
- Top level holds the state_axi_o registers, counter, and irq.

Test Plan:
- Single core (NUM_CORES=1):
  - Stimulus: start_axi_i 0->1; core drops ready 3 cycles later, raises it 10 cycles later with cl_num=7.
  - Response: start_svm_o high 3 cycles; busy_o high throughout START/BUSY; cl_num_axi_o=7; ready_axi_o=1; done_cnt_o=1.
  - Then with irq_en_i=1: irq_o=1 one cycle later. done_ack_i -> ready_axi_o=0, irq_o=0.
- Timeout (TIMEOUT=5):
  - Stimulus: start request; core keeps ready=1.
  - Response: start_svm_o high exactly 5 cycles, err_o=1, FSM back in IDLE, done_cnt unchanged.
- Busy request:
  - Stimulus: toggle start_axi_i 1->0->1 while BUSY.
  - Response: err_o=1; the run completes normally with the correct cl_num; one completion counted.
- Held start level:
  - Stimulus: start_axi_i held high across 3 full runs.
  - Response: only one run occurs.
  - Then: restart from DONE, with req and ack in the same cycle -> new START, ready_axi_o=0.
- NUM_CORES=4:
  - Stimulus: cores 0 and 2 complete in the same cycle with results 3 and 9.
  - Response: slices [3:0]=3 and [11:8]=9; done_cnt_o increments by 2.
  - Saturation: with CNT_W=2 from 3, the counter stays 3.
- Reset:
  - Stimulus: reset=0 asserted while BUSY.
  - Response: next cycle all outputs are 0 and the FSM is in IDLE; after release, ready rising alone causes no capture.
